// File: rtl/mult_ctrl_pkg.sv
// Shared constants and state encoding for the multiplier arbiter slice.
package mult_ctrl_pkg;
    localparam int OP_W        = 8;
    localparam int PROD_W      = 16;
    localparam int N_REQ_DEF   = 4;
    localparam int TIMEOUT_DEF = 31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;
endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side and multiplier-side signals of the arbiter, grouped as one bus.
interface mult_arbiter_if
    import mult_ctrl_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
);
    logic [N_REQ-1:0]      req;
    logic [OP_W*N_REQ-1:0] a_in;
    logic [OP_W*N_REQ-1:0] b_in;
    logic [N_REQ-1:0]      done;
    logic [PROD_W-1:0]     resp_product;
    logic                  resp_err;
    logic                  busy;
    logic                  mul_load;
    logic [OP_W-1:0]       mul_a;
    logic [OP_W-1:0]       mul_b;
    logic [PROD_W-1:0]     mul_product;
    logic                  mul_valid;

    modport slave (
        input  req, a_in, b_in, mul_product, mul_valid,
        output done, resp_product, resp_err, busy, mul_load, mul_a, mul_b
    );

    modport master (
        output req, a_in, b_in, mul_product, mul_valid,
        input  done, resp_product, resp_err, busy, mul_load, mul_a, mul_b
    );
endinterface

// File: rtl/mult_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin
        int pos;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = (int'(ptr) + k) % N_REQ;
            if (!any && req[pos]) begin
                any        = 1'b1;
                idx        = IDX_W'(pos);
                grant[pos] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one external sequential multiplier among N_REQ requesters.
//   state | meaning
//   IDLE  | sample requests, latch winner index and its operands
//   LOAD  | one-cycle load strobe with latched operands
//   WAIT  | await result; first-cycle valid is stale, counter expiry forces error
//   RESP  | one-cycle done/result to the winner, advance pointer
module mult_arbiter
    import mult_ctrl_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          asyn_rst,
    mult_arbiter_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d, idx_q, idx_d;
    logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  rr_grant;
    logic [IDX_W-1:0]  rr_idx;
    logic              rr_any;
    logic [OP_W-1:0]   a_sel, b_sel;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req   (bus.req),
        .ptr   (ptr_q),
        .grant (rr_grant),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (rr_grant[i]) begin
                a_sel = bus.a_in[i*OP_W +: OP_W];
                b_sel = bus.b_in[i*OP_W +: OP_W];
            end
        end
    end

    always_ff @(posedge clk or negedge asyn_rst) begin
        if (!asyn_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        idx_d            = idx_q;
        a_d              = a_q;
        b_d              = b_q;
        prod_d           = prod_q;
        err_d            = err_q;
        cnt_d            = cnt_q;
        bus.done         = '0;
        bus.resp_product = '0;
        bus.resp_err     = 1'b0;
        bus.mul_load     = 1'b0;
        bus.busy         = (state_q != ST_IDLE);
        bus.mul_a        = a_q;
        bus.mul_b        = b_q;
        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    idx_d   = rr_idx;
                    a_d     = a_sel;
                    b_d     = b_sel;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                bus.mul_load = 1'b1;
                cnt_d        = CNT_FIRST;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                // Down-counter starts at TIMEOUT-1, so CNT_FIRST marks the stale-valid cycle.
                if (bus.mul_valid && cnt_q != CNT_FIRST) begin
                    prod_d  = bus.mul_product;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == '0) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                bus.done[idx_q]  = 1'b1;
                bus.resp_product = prod_q;
                bus.resp_err     = err_q;
                ptr_d            = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized scoreboard bench for mult_arbiter with a behavioural sequential multiplier.
module tb_mult_arbiter;
    import mult_ctrl_pkg::*;

    localparam int N = 4;
    localparam int T = TIMEOUT_DEF;

    logic clk = 1'b0;
    logic asyn_rst = 1'b0;
    always #5 clk = ~clk;

    mult_arbiter_if #(.N_REQ(N)) bus ();

    mult_arbiter #(.N_REQ(N), .TIMEOUT(T)) dut (
        .clk      (clk),
        .asyn_rst (asyn_rst),
        .bus      (bus.slave)
    );

    typedef struct {
        int          idx;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    int   n_chk = 0, n_fail = 0;
    int   hang_cnt = 0, hang_seen = 0;
    int   mcyc = 0, load_cyc = 0;
    int   ptr_m = 0;
    bit   auto_drop = 1'b1;
    int   mul_lat = 3;
    bit   mul_dead = 1'b0;

    // Multiplier model: result appears mul_lat cycles after the load; the old
    // valid/product linger through the first WAIT cycle.
    int          mcnt = 0;
    logic [15:0] mp = '0;
    always @(negedge clk or negedge asyn_rst) begin
        if (!asyn_rst) begin
            mcnt            = 0;
            bus.mul_valid   = 1'b0;
            bus.mul_product = '0;
        end else if (bus.mul_load) begin
            mcnt = mul_lat + 1;
            mp   = 16'(bus.mul_a) * 16'(bus.mul_b);
        end else if (mcnt > 0) begin
            mcnt = mcnt - 1;
            if (mcnt == 0) begin
                bus.mul_valid   = !mul_dead;
                bus.mul_product = mp;
            end else if (mcnt < mul_lat) begin
                bus.mul_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk or negedge asyn_rst) begin
        #1;
        if (!asyn_rst) begin
            sb_q.delete();
            chk("rst_busy", 32'(bus.busy), 0);
            chk("rst_done", 32'(bus.done), 0);
            chk("rst_load", 32'(bus.mul_load), 0);
            chk("rst_ops", {16'h0, bus.mul_a, bus.mul_b}, 0);
            chk("rst_resp", {15'h0, bus.resp_err, bus.resp_product}, 0);
        end else begin
            mcyc++;
            if (hang_cnt != hang_seen) begin
                chk("drain_budget", hang_cnt, hang_seen);
                hang_seen = hang_cnt;
            end
            if (bus.mul_load) begin
                load_cyc = mcyc;
                if (sb_q.size() == 0) chk("load_unexpected", 32'(bus.mul_load), 0);
                else begin
                    chk("mul_a", 32'(bus.mul_a), 32'(sb_q[0].a));
                    chk("mul_b", 32'(bus.mul_b), 32'(sb_q[0].b));
                end
            end
            if (bus.done != '0) begin
                if (sb_q.size() == 0) chk("done_unexpected", 32'(bus.done), 0);
                else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("done_onehot", 32'(bus.done), 32'(1) << e.idx);
                    chk("resp_product", 32'(bus.resp_product), 32'(e.prod));
                    chk("resp_err", 32'(bus.resp_err), 32'(e.err));
                    chk("latency", mcyc - load_cyc, e.err ? T + 1 : e.lat + 2);
                end
            end else begin
                chk("resp_quiet", {15'h0, bus.resp_err, bus.resp_product}, 0);
            end
        end
    end

    // Reference arbiter: whenever the DUT is idle with requests present, the
    // winner is the first requester at or after the rotating pointer.
    task automatic step();
        if (asyn_rst && !bus.busy && bus.req != '0) begin
            exp_t e;
            int   w;
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && bus.req[(ptr_m + k) % N]) w = (ptr_m + k) % N;
            end
            e.idx  = w;
            e.a    = bus.a_in[w*8 +: 8];
            e.b    = bus.b_in[w*8 +: 8];
            e.err  = mul_dead;
            e.prod = mul_dead ? 16'h0 : 16'(e.a) * 16'(e.b);
            e.lat  = mul_lat;
            sb_q.push_back(e);
            ptr_m = (w + 1) % N;
        end
        @(negedge clk);
        if (auto_drop) bus.req = bus.req & ~bus.done;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        do begin
            step();
            i++;
        end while (!(sb_q.size() == 0 && !bus.busy && bus.req == '0) && i < budget);
        if (i >= budget) hang_cnt++;
    endtask

    task automatic set_ops(input int r, input logic [7:0] a, input logic [7:0] b);
        bus.a_in[r*8 +: 8] = a;
        bus.b_in[r*8 +: 8] = b;
    endtask

    task automatic rand_ops();
        for (int r = 0; r < N; r++) set_ops(r, 8'($urandom), 8'($urandom));
    endtask

    task automatic apply_reset(input int n);
        #3 asyn_rst = 1'b0;
        repeat (n) @(negedge clk);
        asyn_rst = 1'b1;
        ptr_m    = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        repeat (3) @(negedge clk);
        asyn_rst = 1'b1;

        // single requester, known operands
        set_ops(0, 8'hB7, 8'hC5);
        bus.req = 4'b0001;
        wait_drain(100);

        // all four together after reset: order 0,1,2,3
        apply_reset(2);
        rand_ops();
        bus.req = 4'b1111;
        wait_drain(400);

        // two requesters held continuously alternate
        rand_ops();
        auto_drop = 1'b0;
        bus.req   = 4'b0101;
        repeat (60) step();
        bus.req   = '0;
        auto_drop = 1'b1;
        wait_drain(100);

        // dead multiplier: timeout, then normal service resumes
        mul_dead = 1'b1;
        rand_ops();
        bus.req = 4'b0010;
        wait_drain(200);
        mul_dead = 1'b0;
        rand_ops();
        bus.req = 4'b0010;
        wait_drain(100);

        // reset during WAIT with the request still held
        mul_lat = 6;
        rand_ops();
        bus.req = 4'b0100;
        guard = 0;
        while (!bus.mul_load && guard < 20) begin
            step();
            guard++;
        end
        if (guard >= 20) hang_cnt++;
        step();
        step();
        apply_reset(2);
        wait_drain(100);

        // randomized batches
        for (int it = 0; it < 30; it++) begin
            mul_lat  = $urandom_range(1, 8);
            mul_dead = ($urandom_range(0, 7) == 0);
            rand_ops();
            bus.req  = 4'($urandom);
            wait_drain(800);
        end
        mul_dead = 1'b0;

        // requests and operands toggling while the arbiter is busy
        mul_lat   = 2;
        auto_drop = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.req = bus.req ^ 4'(1 << $urandom_range(0, N - 1));
                rand_ops();
            end
            step();
        end
        bus.req   = '0;
        auto_drop = 1'b1;
        wait_drain(100);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one sequential multiplier.
REQ-002 Parameter TIMEOUT, default 31, maximum cycles spent in WAIT before forcing an error response.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 asyn_rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  N_REQ  per-requester level request; operands held stable while high.
REQ-006 a_in  input  8*N_REQ  packed operand A; slice i belongs to requester i.
REQ-007 b_in  input  8*N_REQ  packed operand B; slice i belongs to requester i.
REQ-008 done  output  N_REQ  one-hot, one-cycle completion pulse to the served requester.
REQ-009 resp_product  output  16  result, valid only in the done cycle.
REQ-010 resp_err  output  1  timeout flag, valid only in the done cycle.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 mul_load  output  1  one-cycle load strobe to the multiplier.
REQ-013 mul_a, mul_b  output  8 each  operands to the multiplier.
REQ-014 mul_product  input  16  multiplier result.
REQ-015 mul_valid  input  1  multiplier result-ready flag.

Function
REQ-016 FSM states IDLE, LOAD, WAIT, RESP; the SHALL set is exactly these four.
REQ-017 IDLE: any req high -> winner chosen round-robin starting at pointer ptr, winner index and its a_in/b_in slices registered, next state LOAD; no req -> stay IDLE.
REQ-018 Round-robin: search ptr, ptr+1, ... wrapping mod N_REQ; first set bit wins.
REQ-019 LOAD: mul_load=1 for exactly one cycle with the registered operands on mul_a/mul_b; next state WAIT.
REQ-020 WAIT: mul_valid ignored in the first WAIT cycle (stale valid from previous operation); from the second cycle, first mul_valid=1 captures mul_product, next state RESP with err=0.
REQ-021 WAIT: cycle counter reaching TIMEOUT without qualifying valid -> next state RESP with err=1, captured product forced to 0.
REQ-022 RESP: done[winner]=1, resp_product and resp_err driven for exactly one cycle; ptr <= (winner+1) mod N_REQ; next state IDLE.
REQ-023 Outside RESP: done=0, resp_product=0, resp_err=0; outside LOAD: mul_load=0 (mul_a/mul_b hold last value).
REQ-024 Requests arriving or changing outside IDLE are not sampled until the next IDLE cycle; a requester dropping req mid-service still receives its done pulse.
REQ-025 Minimum service time req-to-done = 3 cycles + multiplier latency; one IDLE cycle separates consecutive services.
REQ-026 X/Z on operands or mul_product is forwarded unaltered; only timeout sets resp_err.

Reset
REQ-027 asyn_rst=0 immediately forces state IDLE, ptr=0, counter=0, all outputs 0, regardless of clock or current state.
REQ-028 Reset mid-operation abandons the transaction with no done pulse; a still-held req is served afresh after release.

Structure
REQ-029 Shared package mult_ctrl_pkg holds the state encoding, operand width 8, product width 16 and default N_REQ/TIMEOUT constants.
REQ-030 Round-robin selection is a natural sub-module rr_arbiter (req, ptr -> one-hot grant, index, any); the multiplier is instantiated beside mult_arbiter at the top level, not inside it.

Verification
REQ-031 Single req[0], a=0xB7, b=0xC5 with sequential_multiplier attached -> one mul_load pulse with 0xB7/0xC5, done=0001 once, resp_product=0x8CD3, resp_err=0.
REQ-032 req=1111 asserted together after reset, each dropped after its done -> service order 0,1,2,3, each done exactly once, correct products.
REQ-033 req[0] and req[2] held high continuously -> done alternates 0001, 0100, 0001, 0100; requester 0 never served twice in a row.
REQ-034 mul_valid tied 0 -> done pulse exactly TIMEOUT cycles after WAIT entry with resp_err=1, resp_product=0; next request served normally.
REQ-035 mul_valid held 1 entering WAIT -> first WAIT cycle ignored; asyn_rst=0 during WAIT -> all outputs 0 at once, no done, ptr=0, held req re-served after release.
